// File: rtl/input_frame_scheduler_if.sv
// Bundle between the host (UART decoder side / game logic) and input_frame_scheduler.
// master drives frame timing, link activity and key levels; slave returns the per-frame commands.
interface input_frame_scheduler_if;
    logic       frame_tick;
    logic       rx_valid;
    logic [4:0] p1_keys;
    logic [4:0] p2_keys;
    logic       p1_move;
    logic [1:0] p1_dir;
    logic       p1_fire;
    logic       p2_move;
    logic [1:0] p2_dir;
    logic       p2_fire;
    logic       link_alive;
    logic       link_lost;

    modport master (
        output frame_tick, rx_valid, p1_keys, p2_keys,
        input  p1_move, p1_dir, p1_fire, p2_move, p2_dir, p2_fire, link_alive, link_lost
    );

    modport slave (
        input  frame_tick, rx_valid, p1_keys, p2_keys,
        output p1_move, p1_dir, p1_fire, p2_move, p2_dir, p2_fire, link_alive, link_lost
    );
endinterface

// File: rtl/input_frame_scheduler.sv
// Per-frame key sampler: resolves move/dir, schedules fire with cooldown, watchdog-gates a silent UART link.
// Optional INPUT_FIRE_EDGE_EN: a shot also needs a 0->1 fire edge between consecutive frame ticks.
module input_frame_scheduler #(
    parameter int FIRE_COOLDOWN  = 15,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int CNT_W          = 26
) (
    input  logic                    clk,
    input  logic                    rstn,
    input_frame_scheduler_if.slave  bus
);
    localparam logic [0:0] ST_READY    = 1'b0;
    localparam logic [0:0] ST_COOLDOWN = 1'b1;
    localparam int         CD_W        = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CD_W-1:0]  COOLDOWN  = CD_W'(FIRE_COOLDOWN);

    logic [CNT_W-1:0] wd_cnt_reg;
    logic [CNT_W-1:0] wd_cnt_next;
    logic             alive_next;
    logic             link_alive_reg;
    logic             link_lost_reg;

    logic [1:0][4:0]  keys;
    logic [1:0]       move_w;
    logic [1:0][1:0]  dir_w;
    logic [1:0]       fire_w;

    assign keys[0] = bus.p1_keys;
    assign keys[1] = bus.p2_keys;

    // Counter saturates at TIMEOUT so a dead link stays dead without wrapping back to alive.
    always_comb begin
        wd_cnt_next = wd_cnt_reg;
        if (bus.rx_valid)
            wd_cnt_next = '0;
        else if (wd_cnt_reg >= TIMEOUT)
            wd_cnt_next = TIMEOUT;
        else
            wd_cnt_next = wd_cnt_reg + CNT_W'(1);
    end

    assign alive_next = (wd_cnt_next < TIMEOUT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt_reg     <= TIMEOUT;
            link_alive_reg <= 1'b0;
            link_lost_reg  <= 1'b0;
        end else begin
            wd_cnt_reg     <= wd_cnt_next;
            link_alive_reg <= alive_next;
            link_lost_reg  <= link_alive_reg & ~alive_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_player
            logic [4:0]      gated;
            logic            move_reg;
            logic            move_next;
            logic [1:0]      dir_reg;
            logic [1:0]      dir_next;
            logic            fire_reg;
            logic            fire_ok;
            logic [0:0]      state_reg;
            logic [CD_W-1:0] count_reg;

            // Gate uses the alive flag registered before this edge, so a coincident rx_valid cannot unmask.
            assign gated = link_alive_reg ? keys[gi] : 5'd0;

            always_comb begin
                move_next = 1'b0;
                dir_next  = dir_reg;
                if (gated[0] & ~gated[1]) begin
                    move_next = 1'b1;
                    dir_next  = 2'd0;
                end else if (gated[1] & ~gated[0]) begin
                    move_next = 1'b1;
                    dir_next  = 2'd1;
                end else if (gated[2] & ~gated[3]) begin
                    move_next = 1'b1;
                    dir_next  = 2'd2;
                end else if (gated[3] & ~gated[2]) begin
                    move_next = 1'b1;
                    dir_next  = 2'd3;
                end
            end

`ifdef INPUT_FIRE_EDGE_EN
            logic last_fire_reg;

            assign fire_ok = gated[4] & ~last_fire_reg;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)
                    last_fire_reg <= 1'b0;
                else if (bus.frame_tick)
                    last_fire_reg <= gated[4];
            end
`else
            assign fire_ok = gated[4];
`endif

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    move_reg  <= 1'b0;
                    dir_reg   <= 2'd0;
                    fire_reg  <= 1'b0;
                    state_reg <= ST_READY;
                    count_reg <= '0;
                end else begin
                    fire_reg <= 1'b0;
                    if (bus.frame_tick) begin
                        move_reg <= move_next;
                        dir_reg  <= dir_next;
                        case (state_reg)
                            ST_READY: begin
                                if (fire_ok) begin
                                    fire_reg  <= 1'b1;
                                    count_reg <= COOLDOWN;
                                    state_reg <= (FIRE_COOLDOWN > 0) ? ST_COOLDOWN : ST_READY;
                                end
                            end
                            default: begin
                                // Reaching zero only re-arms; the shot waits for the following tick.
                                count_reg <= count_reg - CD_W'(1);
                                if (count_reg == CD_W'(1))
                                    state_reg <= ST_READY;
                            end
                        endcase
                    end
                end
            end

            assign move_w[gi] = move_reg;
            assign dir_w[gi]  = dir_reg;
            assign fire_w[gi] = fire_reg;
        end
    endgenerate

    assign bus.p1_move    = move_w[0];
    assign bus.p1_dir     = dir_w[0];
    assign bus.p1_fire    = fire_w[0];
    assign bus.p2_move    = move_w[1];
    assign bus.p2_dir     = dir_w[1];
    assign bus.p2_fire    = fire_w[1];
    assign bus.link_alive = link_alive_reg;
    assign bus.link_lost  = link_lost_reg;
endmodule

// File: tb/tb_input_frame_scheduler.sv
// Randomized bench for input_frame_scheduler against a per-frame behavioural model.
module tb_input_frame_scheduler;
    localparam int FC = 3;
    localparam int TO = 100;
`ifdef INPUT_FIRE_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    input_frame_scheduler_if bus();

    input_frame_scheduler #(
        .FIRE_COOLDOWN (FC),
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (8)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state: time stamps instead of counters/FSMs
    longint cyc = 0;
    longint last_rx = -1;
    longint tick_n = 0;
    longint last_shot[2] = '{-1, -1};
    bit     prev_fire[2] = '{0, 0};
    bit     m_alive = 0;
    bit     e_move[2] = '{0, 0};
    bit [1:0] e_dir[2] = '{2'd0, 2'd0};
    bit     e_fire[2] = '{0, 0};
    bit     e_lost = 0;
    int     e_shots = 0;
    int     e_losts = 0;

    logic [9:0] act;
    assign act = {bus.p1_move, bus.p1_dir, bus.p1_fire, bus.p2_move, bus.p2_dir, bus.p2_fire,
                  bus.link_alive, bus.link_lost};

    function automatic logic [9:0] exp_vec();
        return {e_move[0], e_dir[0], e_fire[0], e_move[1], e_dir[1], e_fire[1], m_alive, e_lost};
    endfunction

    task automatic model_player(input int p, input logic [4:0] k);
        int v, h;
        bit allowed, shot;
        v = int'(k[0]) - int'(k[1]);
        h = int'(k[3]) - int'(k[2]);
        if (v != 0) begin
            e_move[p] = 1; e_dir[p] = (v > 0) ? 2'd0 : 2'd1;
        end else if (h != 0) begin
            e_move[p] = 1; e_dir[p] = (h > 0) ? 2'd3 : 2'd2;
        end else begin
            e_move[p] = 0;
        end
        allowed = (last_shot[p] < 0) || (tick_n - last_shot[p] >= FC + 1);
        shot = k[4] && allowed && !(EDGE && prev_fire[p]);
        if (shot) begin
            last_shot[p] = tick_n;
            if (p == 0) e_shots++;
        end
        prev_fire[p] = k[4];
        e_fire[p] = shot;
    endtask

    task automatic drive_cycle(input bit rx, input bit tick, input logic [4:0] k1, input logic [4:0] k2);
        bit new_alive;
        @(negedge clk);
        bus.rx_valid = rx;
        bus.frame_tick = tick;
        bus.p1_keys = k1;
        bus.p2_keys = k2;
        @(posedge clk);
        if (tick) begin
            model_player(0, m_alive ? k1 : 5'd0);
            model_player(1, m_alive ? k2 : 5'd0);
            tick_n++;
        end else begin
            e_fire[0] = 0; e_fire[1] = 0;
        end
        if (rx) last_rx = cyc;
        new_alive = (last_rx >= 0) && (cyc - last_rx < TO);
        e_lost = m_alive && !new_alive;
        if (e_lost) e_losts++;
        m_alive = new_alive;
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        bus.rx_valid = 0; bus.frame_tick = 0; bus.p1_keys = 5'd31; bus.p2_keys = 5'd31;
        rstn = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (act !== 10'd0) begin
            errors++; $display("FAIL reset_outputs act=%h exp=%h", act, 10'd0);
        end
        @(negedge clk);
        rstn = 1;
        drive_cycle(0, 1, 5'b00001, 5'b00000);
        checks++;
        if (bus.p1_move !== 1'b0 || bus.link_alive !== 1'b0) begin
            errors++; $display("FAIL dead_link_tick act=%b%b exp=00", bus.p1_move, bus.link_alive);
        end
        $display("test_reset done cycle=%0d", cyc);
    endtask

    task automatic test_direction();
        drive_cycle(1, 0, 5'd0, 5'd0);
        drive_cycle(0, 0, 5'd0, 5'd0);
        drive_cycle(0, 1, 5'b00101, 5'b01100);
        checks++;
        if ({bus.p1_move, bus.p1_dir, bus.p2_move} !== 4'b1000) begin
            errors++; $display("FAIL left_up_cancel act=%b exp=1000", {bus.p1_move, bus.p1_dir, bus.p2_move});
        end
        drive_cycle(1, 1, 5'b00000, 5'b01110);
        checks++;
        if ({bus.p2_move, bus.p2_dir} !== 3'b101) begin
            errors++; $display("FAIL down_wins act=%b exp=101", {bus.p2_move, bus.p2_dir});
        end
        for (int i = 0; i < 60; i++) begin
            drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                        5'($urandom_range(0, 31)));
            checks++;
            if (act !== exp_vec()) begin
                errors++; $display("FAIL direction cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
            end
        end
        $display("test_direction done cycle=%0d", cyc);
    endtask

    task automatic test_fire_cooldown();
        int pulses = 0;
        int shots0;
        // Let any outstanding cooldown/edge state settle with fire released
        for (int i = 0; i < FC + 2; i++) drive_cycle(1, 1, 5'd0, 5'd0);
        shots0 = e_shots;
        for (int t = 0; t < 10; t++) begin
            for (int c = 0; c < 3; c++) begin
                drive_cycle(1, c == 0, 5'b10000, 5'($urandom_range(0, 31)));
                if (bus.p1_fire === 1'b1) pulses++;
                checks++;
                if (act !== exp_vec()) begin
                    errors++; $display("FAIL fire_cycle cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
                end
            end
        end
        checks++;
        if (pulses != e_shots - shots0 || pulses != (EDGE ? 1 : 3)) begin
            errors++; $display("FAIL fire_pulse_count act=%0d exp=%0d", pulses, EDGE ? 1 : 3);
        end
        $display("test_fire_cooldown done pulses=%0d", pulses);
    endtask

    task automatic test_watchdog();
        int losts = 0;
        drive_cycle(1, 0, 5'd0, 5'd0);
        for (int i = 0; i < TO + 5; i++) begin
            drive_cycle(0, 0, 5'b11111, 5'b11111);
            if (bus.link_lost === 1'b1) losts++;
            checks++;
            if (act !== exp_vec()) begin
                errors++; $display("FAIL watchdog cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
            end
        end
        checks++;
        if (losts != 1 || bus.link_alive !== 1'b0) begin
            errors++; $display("FAIL link_lost_once act=%0d/%b exp=1/0", losts, bus.link_alive);
        end
        drive_cycle(1, 1, 5'b10001, 5'b10100);
        checks++;
        if ({bus.p1_move, bus.p1_fire, bus.p2_move, bus.p2_fire} !== 4'b0000) begin
            errors++; $display("FAIL gated_tick act=%b exp=0000",
                               {bus.p1_move, bus.p1_fire, bus.p2_move, bus.p2_fire});
        end
        $display("test_watchdog done losts=%0d", losts);
    endtask

    task automatic test_back_to_back();
        int rx_pct;
        for (int ph = 0; ph < 6; ph++) begin
            rx_pct = (ph % 2 == 0) ? 30 : ((ph == 3) ? 0 : 2);
            for (int i = 0; i < 150; i++) begin
                drive_cycle($urandom_range(0, 99) < rx_pct, $urandom_range(0, 2) != 0,
                            5'($urandom_range(0, 31)) | 5'(($urandom_range(0, 1)) << 4),
                            5'($urandom_range(0, 31)));
                checks++;
                if (act !== exp_vec()) begin
                    errors++; $display("FAIL back_to_back cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
                end
            end
        end
        $display("test_back_to_back done cycle=%0d losts=%0d", cyc, e_losts);
    endtask

    initial begin
        test_reset();
        test_direction();
        test_fire_cooldown();
        test_watchdog();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
